// File: rtl/bsg_cgol_pkg.sv
// Shared definitions for the Game of Life controller and anything that
// needs to agree with it on state encoding and cell numbering.
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    eIDLE,
    eLOAD,
    eSIM,
    eDONE
  } cgol_state_e;

  // Cells are numbered row-major: bit k of a board vector is cell (k / width, k % width).
  function automatic int cell_idx(input int row, input int col, input int width);
    return row * width + col;
  endfunction

endpackage

// File: rtl/bsg_cgol_frame_counter.sv
// Loadable generation down-counter. A load above max_val_p clamps to
// max_val_p. The counter stops at zero rather than wrapping.
module bsg_cgol_frame_counter #(
  parameter int max_val_p = 1024,
  parameter int width_p   = 11
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               dec_i,
  input  logic [width_p-1:0] val_i,
  output logic               is_zero_o,
  output logic               is_one_o
);

  localparam logic [width_p-1:0] max_lp = max_val_p[width_p-1:0];
  localparam logic [width_p-1:0] one_lp = {{(width_p-1){1'b0}}, 1'b1};

  logic [width_p-1:0] cnt_r;

  // Load with saturation, otherwise count down while enabled.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_r <= '0;
    else if (load_i)
      cnt_r <= (val_i > max_lp) ? max_lp : val_i;
    else if (dec_i && (cnt_r != '0))
      cnt_r <= cnt_r - one_lp;
  end

  assign is_zero_o = (cnt_r == '0);
  assign is_one_o  = (cnt_r == one_lp);

endmodule

// File: rtl/bsg_cgol_ctrl.sv
// Game of Life sequencing controller: takes a board and a generation
// count, loads the cell array, runs it for that many generations, then
// holds the resulting board until the consumer takes it.
module bsg_cgol_ctrl
  import bsg_cgol_pkg::*;
#(
  parameter  int board_width_p     = 8,
  parameter  int max_game_length_p = 1024,
  localparam int num_cells_lp      = board_width_p * board_width_p,
  localparam int game_len_width_lp = $clog2(max_game_length_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [num_cells_lp-1:0]      data_i,
  input  logic [game_len_width_lp-1:0] frames_i,
  output logic                         update_o,
  output logic [num_cells_lp-1:0]      update_val_o,
  output logic                         en_o,
  input  logic [num_cells_lp-1:0]      board_i,
  output logic                         v_o,
  output logic [num_cells_lp-1:0]      data_o,
  input  logic                         yumi_i
);

  cgol_state_e             state_r, state_n;
  logic [num_cells_lp-1:0] board_r;
  logic                    accept;
  logic                    cnt_zero, cnt_one;

  assign accept = v_i & ready_o;

  bsg_cgol_frame_counter #(
    .max_val_p(max_game_length_p),
    .width_p  (game_len_width_lp)
  ) frame_cnt (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (accept),
    .dec_i    (state_r == eSIM),
    .val_i    (frames_i),
    .is_zero_o(cnt_zero),
    .is_one_o (cnt_one)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= eIDLE;
    else         state_r <= state_n;
  end

  // Board register holds the starting board only until it is loaded.
  always_ff @(posedge clk_i) begin
    if (reset_i)     board_r <= '0;
    else if (accept) board_r <= data_i;
  end

  // Next-state and output decode. update_o and en_o live in disjoint
  // states, so the cells never see both in the same cycle.
  always_comb begin
    state_n      = state_r;
    ready_o      = 1'b0;
    update_o     = 1'b0;
    update_val_o = '0;
    en_o         = 1'b0;
    v_o          = 1'b0;
    data_o       = '0;
    case (state_r)
      eIDLE: begin
        ready_o = 1'b1;
        if (v_i) state_n = eLOAD;
      end
      eLOAD: begin
        update_o     = 1'b1;
        update_val_o = board_r;
        state_n      = cnt_zero ? eDONE : eSIM;
      end
      eSIM: begin
        en_o = 1'b1;
        if (cnt_one) state_n = eDONE;
      end
      eDONE: begin
        // Cells are frozen here, so their outputs are the result.
        v_o    = 1'b1;
        data_o = board_i;
        if (yumi_i) state_n = eIDLE;
      end
      default: state_n = eIDLE;
    endcase
  end

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// Directed bench for bsg_cgol_ctrl on a 5x5 board with a behavioural cell array.
module tb_bsg_cgol_ctrl;
  import bsg_cgol_pkg::*;

  localparam int W  = 5;
  localparam int NC = W * W;
  localparam int ML = 1024;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset_i, v_i, ready_o, update_o, en_o, v_o, yumi_i;
  logic [NC-1:0] data_i, update_val_o, board, data_o;
  logic [LW-1:0] frames_i;

  int nvec = 0;
  int nmis = 0;

  localparam logic [NC-1:0] HBLINK  = 25'h0003800;  // cells 11,12,13
  localparam logic [NC-1:0] VBLINK  = 25'h0021080;  // cells 7,12,17
  localparam logic [NC-1:0] GLIDER0 = 25'h0001C82;  // cells 1,7,10,11,12
  localparam logic [NC-1:0] GLIDER1 = 25'h00118A0;  // cells 5,7,11,12,16

  bsg_cgol_ctrl #(.board_width_p(W), .max_game_length_p(ML)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .data_i(data_i), .frames_i(frames_i), .update_o(update_o),
    .update_val_o(update_val_o), .en_o(en_o), .board_i(board),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  always #5 clk = ~clk;

  // Behavioural cell array: dead cells beyond the board edge.
  function automatic logic [NC-1:0] life(input logic [NC-1:0] b);
    logic [NC-1:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < W && c+dc >= 0 && c+dc < W)
              cnt += int'(b[cell_idx(r+dr, c+dc, W)]);
        n[cell_idx(r, c, W)] = (cnt == 3) || (b[cell_idx(r, c, W)] && cnt == 2);
      end
    return n;
  endfunction

  always @(posedge clk) begin
    if (update_o)  board <= update_val_o;
    else if (en_o) board <= life(board);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers one game from eIDLE and returns in the first cycle with v_o=1
  // (or after the cycle budget runs out).
  task automatic run_game(input string tag, input logic [NC-1:0] d, input logic [LW-1:0] f,
                          input int n_exp, input logic [NC-1:0] exp_board);
    int lat, ens, ups, both;
    check({tag, "_idle_ready"}, ready_o, 1);
    v_i = 1'b1; data_i = d; frames_i = f;
    step();
    v_i = 1'b0; data_i = NC'($urandom); frames_i = LW'($urandom);
    check({tag, "_load_update"}, update_o, 1);
    check({tag, "_load_val"}, update_val_o, d);
    check({tag, "_load_ready"}, ready_o, 0);
    lat = 1; ens = 0; ups = 0; both = 0;
    while (!v_o && lat < 3000) begin
      if (en_o) ens++;
      if (update_o) ups++;
      if (en_o && update_o) both++;
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, n_exp + 2);
    check({tag, "_en_cycles"}, ens, n_exp);
    check({tag, "_update_pulses"}, ups, 1);
    check({tag, "_upd_en_overlap"}, both, 0);
    check({tag, "_v_o"}, v_o, 1);
    check({tag, "_data_o"}, data_o, exp_board);
  endtask

  task automatic consume();
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0; frames_i = '0;
    step(); step();
    reset_i = 1'b0;
    check("rst_ready", ready_o, 1);
    check("rst_update", update_o, 0);
    check("rst_en", en_o, 0);
    check("rst_v_o", v_o, 0);
    check("rst_update_val", update_val_o, 0);
    check("rst_data_o", data_o, 0);

    // Horizontal blinker for 3 generations ends vertical.
    run_game("blink3", HBLINK, 3, 3, VBLINK);
    consume();
    check("blink3_after_yumi_ready", ready_o, 1);
    check("blink3_after_yumi_v_o", v_o, 0);

    // Zero generations: board comes back exactly as loaded.
    run_game("zero", GLIDER0, 0, 0, GLIDER0);
    consume();

    // Backpressure: stay in eDONE while new games are offered.
    run_game("bp", HBLINK, 1, 1, VBLINK);
    for (int i = 0; i < 20; i++) begin
      v_i = i[0]; data_i = NC'($urandom); frames_i = 0;
      step();
      check("bp_hold_v_o", v_o, 1);
      check("bp_hold_data_o", data_o, VBLINK);
      check("bp_hold_ready", ready_o, 0);
      check("bp_hold_quiet", {update_o, en_o}, 0);
    end
    v_i = 1'b0;
    consume();
    check("bp_ready_after_yumi", ready_o, 1);
    check("bp_no_load_after_yumi", update_o, 0);

    // Reset during the fourth simulated generation.
    check("mid_idle_ready", ready_o, 1);
    v_i = 1'b1; data_i = HBLINK; frames_i = 10;
    step();
    v_i = 1'b0;
    step(); step(); step(); step();
    check("mid_fourth_en", en_o, 1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("mid_rst_ready", ready_o, 1);
    check("mid_rst_en", en_o, 0);
    check("mid_rst_v_o", v_o, 0);
    check("mid_rst_update", update_o, 0);
    run_game("post_rst", HBLINK, 2, 2, HBLINK);
    consume();

    // Longest legal game, then an over-range request that must clamp.
    run_game("max", HBLINK, LW'(ML), ML, HBLINK);
    consume();
    run_game("sat", HBLINK, LW'(ML + 5), ML, HBLINK);
    consume();

    // Back-to-back games with immediate consumption: one idle cycle between.
    run_game("b2b_a", HBLINK, 2, 2, HBLINK);
    consume();
    run_game("b2b_b", GLIDER0, 1, 1, GLIDER1);
    consume();
    check("b2b_end_ready", ready_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
